br_pre_data_rd_ctrl: RTL

Read-side controller for the 1024x256 pre-data FIFO and its companion frame-length descriptor FIFO. It pops one descriptor (frame length in bytes), drains exactly ceil(len/32) 256-bit words from the data FIFO, and presents them as a valid/ready word stream with sop/eop/byte-modulo tags. It sits between the pre-data buffering and the downstream MAC TX/framing logic. It is the consumer counterpart to the FIFO write side.

---
 rtl/br_pre_data_rd_ctrl_pkg.sv | 31 +++
 rtl/br_pre_data_rd_ctrl_skid2.sv | 52 +++++
 rtl/br_pre_data_rd_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/br_pre_data_rd_ctrl_pkg.sv
// Shared types and constants for the pre-data FIFO read controller.
// Frame length in bytes maps to a 12-bit word count and a last-word byte modulo.
package br_pre_pkg;

  localparam int WORD_BYTES = 32;
  localparam int MOD_W      = 5;
  localparam int WCNT_W     = 12;
  localparam int DATA_W     = 256;
  localparam int LEN_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DESC = 2'd1,
    XFER = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
  } word_t;

  // ceil(len/32); the 17-bit sum keeps len=65535 from wrapping.
  function automatic logic [WCNT_W-1:0] len_to_words(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(WORD_BYTES - 1);
    return sum[LEN_W:5];
  endfunction

endpackage

// File: rtl/br_pre_data_rd_ctrl_skid2.sv
// Two-entry in-order buffer of tagged stream words; head is entry 0.
// Push and pop in the same cycle are allowed; the producer never pushes when full.
module br_skid2
  import br_pre_pkg::*;
(
  input  logic       clk,
  input  logic       reset_,
  input  logic       push,
  input  word_t      push_word,
  input  logic       pop,
  output word_t      head,
  output logic [1:0] buf_cnt
);

  word_t      e0;
  word_t      e1;
  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_word;
          else             e1 <= push_word;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; new word lands behind whatever remains.
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= push_word;
          end else begin
            e0 <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign head    = e0;
  assign buf_cnt = cnt;

endmodule

// File: rtl/br_pre_data_rd_ctrl.sv
// Pops a frame-length descriptor, drains ceil(len/32) words from the pre-data FIFO
// and emits them as a tagged stream. out_valid/out_ready: a word moves on any cycle both are high.
module br_pre_data_rd_ctrl
  import br_pre_pkg::state_t;
  import br_pre_pkg::word_t;
  import br_pre_pkg::IDLE;
  import br_pre_pkg::DESC;
  import br_pre_pkg::XFER;
  import br_pre_pkg::len_to_words;
#(
  parameter int WIDTH = 256,
  parameter int LEN_W = 16,
  parameter int MOD_W = 5
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [LEN_W-1:0] desc_q,
  input  logic             desc_empty,
  output logic             desc_rdreq,
  input  logic [WIDTH-1:0] fifo_q,
  input  logic             fifo_empty,
  output logic             fifo_rdreq,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [MOD_W-1:0] out_mod,
  input  logic             out_ready,
  output logic             len_err,
  output logic [31:0]      frm_cnt,
  output state_t           dbg_state
);

  state_t     state;
  state_t     state_nxt;
  logic [11:0] words;
  logic [11:0] iss;
  logic [MOD_W-1:0] mod_r;
  logic       inflight;
  logic       tag_sop;
  logic       tag_eop;
  logic [MOD_W-1:0] tag_mod;
  logic       rd;
  logic       pop;
  logic [2:0] occ;
  logic [1:0] buf_cnt;
  word_t      head;
  word_t      push_word;

  assign pop = out_valid & out_ready;

  always_comb begin
    state_nxt  = state;
    desc_rdreq = 1'b0;
    rd         = 1'b0;
    occ        = {1'b0, buf_cnt} + {2'b00, inflight};
    case (state)
      IDLE: begin
        if (!desc_empty) begin
          desc_rdreq = 1'b1;
          state_nxt  = DESC;
        end
      end
      DESC: begin
        state_nxt = (desc_q == '0) ? IDLE : XFER;
      end
      XFER: begin
        // Buffered plus in-flight words, less this cycle's pop, must leave room.
        if (!fifo_empty && (iss < words) && (occ < (3'd2 + {2'b00, pop}))) begin
          rd = 1'b1;
          if (iss == words - 12'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_rdreq = rd;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state    <= IDLE;
      words    <= '0;
      iss      <= '0;
      mod_r    <= '0;
      inflight <= 1'b0;
      tag_sop  <= 1'b0;
      tag_eop  <= 1'b0;
      tag_mod  <= '0;
      len_err  <= 1'b0;
      frm_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= rd;
      len_err  <= (state == DESC) && (desc_q == '0);
      if (state == DESC) begin
        words <= len_to_words(desc_q);
        mod_r <= desc_q[MOD_W-1:0];
        iss   <= '0;
      end else if (rd) begin
        iss <= iss + 12'd1;
      end
      // Tags ride alongside the read and meet fifo_q one cycle later.
      if (rd) begin
        tag_sop <= (iss == 12'd0);
        tag_eop <= (iss == words - 12'd1);
        tag_mod <= (iss == words - 12'd1) ? mod_r : '0;
      end
      if (pop && head.eop) frm_cnt <= frm_cnt + 32'd1;
    end
  end

  always_comb begin
    push_word      = '0;
    push_word.data = fifo_q;
    push_word.sop  = tag_sop;
    push_word.eop  = tag_eop;
    push_word.mod  = tag_mod;
  end

  br_skid2 u_skid (
    .clk       (clk),
    .reset_    (reset_),
    .push      (inflight),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .buf_cnt   (buf_cnt)
  );

  // Outputs are forced to zero when nothing is buffered so stale entries never leak.
  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_sop   = out_valid & head.sop;
  assign out_eop   = out_valid & head.eop;
  assign out_mod   = out_valid ? head.mod : '0;
  assign dbg_state = state;

endmodule
